// File: rtl/wave_pkg.sv
// Shared constants and types for the waveform fetch path: buffer geometry, Y width,
// fetch FSM states and the sample-code to screen-row scaler.
package wave_pkg;
    localparam int BUF_AW    = 14;
    localparam int BUF_DEPTH = 16384;
    localparam int Y_W       = 9;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    // Code 255 lands on top; the 17-bit product is shifted and the sum truncated to Y_W bits.
    function automatic logic [Y_W-1:0] scale_y(input logic [7:0]     d,
                                               input logic [Y_W-1:0] top,
                                               input logic [8:0]     span);
        logic [16:0] prod;
        prod = {9'd0, ~d} * {8'd0, span};
        return top + prod[16:8];
    endfunction
endpackage

// File: rtl/wave_fetch_if.sv
// Buffer read port and column-record write port of the waveform fetch stage.
// master = fetch stage, slave = buffer/renderer side.
interface wave_fetch_if;
    import wave_pkg::*;

    logic           ram_rd_en;
    logic [14:0]    ram_addr;
    logic [7:0]     ram_dout_a;
    logic [7:0]     ram_dout_b;
    logic           col_we;
    logic [9:0]     col_addr;
    logic [Y_W-1:0] col_ya_min;
    logic [Y_W-1:0] col_ya_max;
    logic [Y_W-1:0] col_yb_min;
    logic [Y_W-1:0] col_yb_max;

    modport master (
        output ram_rd_en, ram_addr, col_we, col_addr,
               col_ya_min, col_ya_max, col_yb_min, col_yb_max,
        input  ram_dout_a, ram_dout_b
    );

    modport slave (
        input  ram_rd_en, ram_addr, col_we, col_addr,
               col_ya_min, col_ya_max, col_yb_min, col_yb_max,
        output ram_dout_a, ram_dout_b
    );
endinterface

// File: rtl/wave_yscale.sv
// Per-channel scaler: y registered on d_vld, column span registered on y_vld (2 cycles).
// No backpressure; WAVE_FETCH_SPAN_EN selects connected-line spans, otherwise dot mode.
module wave_yscale
    import wave_pkg::*;
#(
    parameter int Y_TOP  = 40,
    parameter int Y_SPAN = 400
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           d_vld,
    input  logic [7:0]     d,
    input  logic           y_vld,
`ifdef WAVE_FETCH_SPAN_EN
    input  logic           y_first,
`endif
    output logic [Y_W-1:0] y_min,
    output logic [Y_W-1:0] y_max
);
    logic [Y_W-1:0] y_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_cur <= '0;
        end else if (d_vld) begin
            y_cur <= scale_y(d, Y_W'(Y_TOP), 9'(Y_SPAN));
        end
    end

`ifdef WAVE_FETCH_SPAN_EN
    logic [Y_W-1:0] y_prev;
    logic [Y_W-1:0] y_ref;

    // Column 0 has no left neighbour, so it spans only its own sample.
    assign y_ref = y_first ? y_cur : y_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_prev <= '0;
            y_min  <= '0;
            y_max  <= '0;
        end else if (y_vld) begin
            y_prev <= y_cur;
            y_min  <= (y_ref < y_cur) ? y_ref : y_cur;
            y_max  <= (y_ref > y_cur) ? y_ref : y_cur;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_min <= '0;
            y_max <= '0;
        end else if (y_vld) begin
            y_min <= y_cur;
            y_max <= y_cur;
        end
    end
`endif
endmodule

// File: rtl/wave_fetch.sv
// Waveform fetch: per request reads H_PIXELS samples per channel from trigger minus pre-trigger, writes one
// column record per pixel RD_LAT+2 cycles after its address; no backpressure. Macro WAVE_FETCH_SPAN_EN: spans.
module wave_fetch
    import wave_pkg::*;
#(
    parameter int H_PIXELS = 800,
    parameter int RD_LAT   = 2,
    parameter int Y_TOP    = 40,
    parameter int Y_SPAN   = 400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              display_en,
    output logic              display_done,
    input  logic [BUF_AW-1:0] trig_pos,
    input  logic [BUF_AW-1:0] pre_trig,
    output logic              busy,
    wave_fetch_if.master      bus
);
    localparam logic [9:0] LAST_COL = 10'(H_PIXELS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              en_meta;
    logic              en_s;
    logic              start_frame;
    logic              abort;
    logic [BUF_AW-1:0] start;
    logic [9:0]        rd_cnt;
    logic [9:0]        wr_idx;
    logic [RD_LAT-1:0] vld_sr;
    logic              d_vld;
    logic              y_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            en_meta <= display_en;
            en_s    <= en_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (en_s && !display_done) begin
                    start_frame = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                if (!en_s) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (rd_cnt == LAST_COL) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!en_s) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.col_we && bus.col_addr == LAST_COL) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!en_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign display_done  = (state == DONE);
    assign busy          = (state == FETCH) || (state == DRAIN);
    assign bus.ram_rd_en = (state == FETCH);
    assign bus.ram_addr  = bus.ram_rd_en ? {1'b0, start + BUF_AW'(rd_cnt)} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start  <= '0;
            rd_cnt <= '0;
        end else if (start_frame) begin
            start  <= trig_pos - pre_trig;
            rd_cnt <= '0;
        end else if (bus.ram_rd_en) begin
            rd_cnt <= rd_cnt + 10'd1;
        end
    end

    // An abort empties the pipe so nothing from the dropped frame reaches the renderer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr       <= '0;
            y_vld        <= 1'b0;
            bus.col_we   <= 1'b0;
            bus.col_addr <= '0;
            wr_idx       <= '0;
        end else begin
            if (abort) begin
                vld_sr     <= '0;
                y_vld      <= 1'b0;
                bus.col_we <= 1'b0;
            end else begin
                vld_sr[0] <= bus.ram_rd_en;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                end
                y_vld      <= vld_sr[RD_LAT-1];
                bus.col_we <= y_vld;
            end
            if (start_frame) begin
                wr_idx <= '0;
            end else if (y_vld) begin
                bus.col_addr <= wr_idx;
                wr_idx       <= wr_idx + 10'd1;
            end
        end
    end

    assign d_vld = vld_sr[RD_LAT-1];

    wave_yscale #(.Y_TOP(Y_TOP), .Y_SPAN(Y_SPAN)) u_yscale_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_vld   (d_vld),
        .d       (bus.ram_dout_a),
        .y_vld   (y_vld),
`ifdef WAVE_FETCH_SPAN_EN
        .y_first (wr_idx == '0),
`endif
        .y_min   (bus.col_ya_min),
        .y_max   (bus.col_ya_max)
    );

    wave_yscale #(.Y_TOP(Y_TOP), .Y_SPAN(Y_SPAN)) u_yscale_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_vld   (d_vld),
        .d       (bus.ram_dout_b),
        .y_vld   (y_vld),
`ifdef WAVE_FETCH_SPAN_EN
        .y_first (wr_idx == '0),
`endif
        .y_min   (bus.col_yb_min),
        .y_max   (bus.col_yb_max)
    );
endmodule
